// File: rtl/game_pkg.sv
// Shared types for the shape-guessing game controller.
// State encoding, shape code type and the empty-slot constant.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GUESS,
    S_GRADE,
    S_DONE
  } state_e;

  typedef logic [2:0] shape_t;

  localparam shape_t SHAPE_EMPTY = 3'b000;

  function automatic logic all_loaded(
    input logic [11:0] p
  );
    return (p[2:0]  != SHAPE_EMPTY) &&
           (p[5:3]  != SHAPE_EMPTY) &&
           (p[8:6]  != SHAPE_EMPTY) &&
           (p[11:9] != SHAPE_EMPTY);
  endfunction

endpackage

// File: rtl/shape_grader.sv
// Combinational scoring of a four-slot guess against the master.
// znarly = exact hits, zood = colour-only hits.
module shape_grader
  import game_pkg::*;
(
  input  logic [11:0] master,
  input  logic [11:0] guess,
  output logic [3:0]  znarly,
  output logic [3:0]  zood
);

  logic [3:0] total;
  logic [3:0] mc;
  logic [3:0] gc;

  always_comb begin
    znarly = '0;
    total  = '0;
    mc     = '0;
    gc     = '0;
    for (int i = 0; i < 4; i++) begin
      znarly = znarly +
        4'(master[3*i +: 3] == guess[3*i +: 3]);
    end
    // Empty code 0 is never in the master, so it never scores.
    for (int c = 1; c < 8; c++) begin
      mc = '0;
      gc = '0;
      for (int i = 0; i < 4; i++) begin
        mc = mc + 4'(master[3*i +: 3] == shape_t'(c));
        gc = gc + 4'(guess[3*i +: 3] == shape_t'(c));
      end
      total = total + ((mc < gc) ? mc : gc);
    end
    zood = total - znarly;
  end

endmodule

// File: rtl/game_controller.sv
// Coin-operated shape-guessing game: load a hidden pattern,
// then grade up to MAX_ROUNDS guesses against it.
module game_controller
  import game_pkg::*;
#(
  parameter int MAX_ROUNDS = 8,
  parameter int MAX_GAMES  = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        CoinDrop,
  input  logic        StartGame,
  input  logic [2:0]  LoadShape,
  input  logic [1:0]  ShapeLocation,
  input  logic        LoadShapeNow,
  input  logic [11:0] Guess,
  input  logic        GradeIt,
  output logic [3:0]  NumGames,
  output logic [3:0]  RoundNumber,
  output logic [3:0]  Znarly,
  output logic [3:0]  Zood,
  output logic        GameWon,
  output logic        GameOver,
  output logic        Loading
);

  state_e      state_q, state_d;
  logic [3:0]  games_q, games_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  zn_q, zn_d;
  logic [3:0]  zo_q, zo_d;
  logic        won_q, won_d;
  logic        over_q, over_d;
  logic        loading_q, loading_d;
  logic [11:0] master_q, master_d;
  logic [11:0] guess_q, guess_d;
  logic        load_prev_q, load_prev_d;
  logic        grade_prev_q, grade_prev_d;

  logic       load_rise;
  logic       grade_rise;
  logic       start_ok;
  logic       coin_inc;
  logic       win;
  logic [3:0] g_zn;
  logic [3:0] g_zo;

  shape_grader u_grader (
    .master (master_q),
    .guess  (guess_q),
    .znarly (g_zn),
    .zood   (g_zo)
  );

  assign load_rise  = LoadShapeNow & ~load_prev_q;
  assign grade_rise = GradeIt & ~grade_prev_q;
  assign win        = (g_zn == 4'd4);
  assign start_ok   = StartGame && (games_q != '0) &&
                      (state_q == S_IDLE ||
                       state_q == S_DONE);
  assign coin_inc   = CoinDrop &&
                      (games_q != 4'(MAX_GAMES));

  always_comb begin
    state_d      = state_q;
    games_d      = games_q;
    round_d      = round_q;
    zn_d         = zn_q;
    zo_d         = zo_q;
    won_d        = won_q;
    master_d     = master_q;
    guess_d      = guess_q;
    load_prev_d  = LoadShapeNow;
    grade_prev_d = GradeIt;

    // A coin paying for the game being started cancels out.
    if (start_ok && !CoinDrop)
      games_d = games_q - 4'd1;
    else if (!start_ok && coin_inc)
      games_d = games_q + 4'd1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          master_d = '0;
          round_d  = '0;
          zn_d     = '0;
          zo_d     = '0;
          won_d    = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (all_loaded(master_q))
          state_d = S_GUESS;
        else if (load_rise &&
                 LoadShape != SHAPE_EMPTY &&
                 master_q[3*ShapeLocation +: 3]
                   == SHAPE_EMPTY)
          master_d[3*ShapeLocation +: 3] = LoadShape;
      end
      S_GUESS: begin
        if (grade_rise) begin
          guess_d = Guess;
          state_d = S_GRADE;
        end
      end
      S_GRADE: begin
        zn_d    = g_zn;
        zo_d    = g_zo;
        round_d = round_q + 4'd1;
        won_d   = win;
        if (win ||
            round_q + 4'd1 == 4'(MAX_ROUNDS))
          state_d = S_DONE;
        else
          state_d = S_GUESS;
      end
      default: state_d = S_IDLE;
    endcase

    loading_d = (state_d == S_LOAD);
    over_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      games_q      <= '0;
      round_q      <= '0;
      zn_q         <= '0;
      zo_q         <= '0;
      won_q        <= 1'b0;
      over_q       <= 1'b0;
      loading_q    <= 1'b0;
      master_q     <= '0;
      guess_q      <= '0;
      load_prev_q  <= 1'b0;
      grade_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      games_q      <= games_d;
      round_q      <= round_d;
      zn_q         <= zn_d;
      zo_q         <= zo_d;
      won_q        <= won_d;
      over_q       <= over_d;
      loading_q    <= loading_d;
      master_q     <= master_d;
      guess_q      <= guess_d;
      load_prev_q  <= load_prev_d;
      grade_prev_q <= grade_prev_d;
    end
  end

  assign NumGames    = games_q;
  assign RoundNumber = round_q;
  assign Znarly      = zn_q;
  assign Zood        = zo_q;
  assign GameWon     = won_q;
  assign GameOver    = over_q;
  assign Loading     = loading_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed and randomized bench for game_controller against
// a game-rules model (coins, slots, per-code counting).
module tb_game_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        CoinDrop = 1'b0;
  logic        StartGame = 1'b0;
  logic [2:0]  LoadShape = '0;
  logic [1:0]  ShapeLocation = '0;
  logic        LoadShapeNow = 1'b0;
  logic [11:0] Guess = '0;
  logic        GradeIt = 1'b0;
  logic [3:0]  NumGames;
  logic [3:0]  RoundNumber;
  logic [3:0]  Znarly;
  logic [3:0]  Zood;
  logic        GameWon;
  logic        GameOver;
  logic        Loading;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 loading, 2 guessing, 3 over
  int m_phase;
  int m_games;
  int m_round;
  int m_zn;
  int m_zo;
  bit m_won;
  int m_master[4];

  game_controller dut (
    .clock         (clock),
    .reset         (reset),
    .CoinDrop      (CoinDrop),
    .StartGame     (StartGame),
    .LoadShape     (LoadShape),
    .ShapeLocation (ShapeLocation),
    .LoadShapeNow  (LoadShapeNow),
    .Guess         (Guess),
    .GradeIt       (GradeIt),
    .NumGames      (NumGames),
    .RoundNumber   (RoundNumber),
    .Znarly        (Znarly),
    .Zood          (Zood),
    .GameWon       (GameWon),
    .GameOver      (GameOver),
    .Loading       (Loading)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, " NumGames"}, 8'(NumGames), 8'(m_games));
    chk({ctx, " Round"}, 8'(RoundNumber), 8'(m_round));
    chk({ctx, " Znarly"}, 8'(Znarly), 8'(m_zn));
    chk({ctx, " Zood"}, 8'(Zood), 8'(m_zo));
    chk({ctx, " GameWon"}, 8'(GameWon), 8'(m_won));
    chk({ctx, " GameOver"}, 8'(GameOver),
        8'(m_phase == 3));
    chk({ctx, " Loading"}, 8'(Loading),
        8'(m_phase == 1));
  endtask

  function automatic void score(
    input  logic [11:0] m,
    input  logic [11:0] g,
    output int          zn,
    output int          zo
  );
    int mc[8];
    int gc[8];
    int tot;
    zn = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      mc[c] = 0;
      gc[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      int a;
      int b;
      a = int'(m[3*i +: 3]);
      b = int'(g[3*i +: 3]);
      if (a == b) zn++;
      mc[a]++;
      gc[b]++;
    end
    for (int c = 1; c < 8; c++)
      tot += (mc[c] < gc[c]) ? mc[c] : gc[c];
    zo = tot - zn;
  endfunction

  function automatic logic [11:0] packed_master();
    return {3'(m_master[3]), 3'(m_master[2]),
            3'(m_master[1]), 3'(m_master[0])};
  endfunction

  function automatic bit master_full();
    return m_master[0] != 0 && m_master[1] != 0 &&
           m_master[2] != 0 && m_master[3] != 0;
  endfunction

  task automatic clear_model();
    m_phase = 0;
    m_games = 0;
    m_round = 0;
    m_zn = 0;
    m_zo = 0;
    m_won = 0;
    for (int i = 0; i < 4; i++) m_master[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic coin();
    CoinDrop = 1'b1;
    tick();
    CoinDrop = 1'b0;
    if (m_games < 7) m_games++;
  endtask

  task automatic start(input bit with_coin);
    StartGame = 1'b1;
    CoinDrop = with_coin;
    tick();
    StartGame = 1'b0;
    CoinDrop = 1'b0;
    if ((m_phase == 0 || m_phase == 3) && m_games > 0) begin
      if (!with_coin) m_games--;
      m_phase = 1;
      m_round = 0;
      m_zn = 0;
      m_zo = 0;
      m_won = 0;
      for (int i = 0; i < 4; i++) m_master[i] = 0;
    end else if (with_coin && m_games < 7) begin
      m_games++;
    end
    check_all("start");
  endtask

  task automatic load(input int slot, input int shape);
    ShapeLocation = 2'(slot);
    LoadShape = 3'(shape);
    LoadShapeNow = 1'b1;
    tick();
    LoadShapeNow = 1'b0;
    if (m_phase == 1 && shape != 0 && m_master[slot] == 0)
      m_master[slot] = shape;
    check_all("load");
    tick();
    if (m_phase == 1 && master_full()) m_phase = 2;
    check_all("load+1");
  endtask

  task automatic load_pattern(input logic [11:0] p);
    for (int i = 0; i < 4; i++)
      load(i, int'(p[3*i +: 3]));
  endtask

  task automatic grade(input logic [11:0] g);
    int zn;
    int zo;
    Guess = g;
    GradeIt = 1'b1;
    tick();
    GradeIt = 1'b0;
    tick();
    if (m_phase == 2) begin
      score(packed_master(), g, zn, zo);
      m_round++;
      m_zn = zn;
      m_zo = zo;
      m_won = (zn == 4);
      if (m_won || m_round == 8) m_phase = 3;
    end
    check_all("grade");
  endtask

  function automatic logic [11:0] rand_master();
    logic [11:0] p;
    for (int i = 0; i < 4; i++)
      p[3*i +: 3] = 3'($urandom_range(1, 7));
    return p;
  endfunction

  function automatic logic [11:0] losing_guess(
    input logic [11:0] p
  );
    logic [11:0] g;
    g = 12'($urandom);
    if (g == p) g = ~p;
    return g;
  endfunction

  task automatic new_game(input logic [11:0] p);
    coin();
    start(1'b0);
    load_pattern(p);
  endtask

  initial begin
    logic [11:0] p;
    clear_model();
    do_reset();
    check_all("reset");

    // Coin saturation, then coin + start at the limit.
    for (int i = 0; i < 9; i++) coin();
    chk("sat NumGames", 8'(NumGames), 8'd7);
    check_all("sat");
    start(1'b1);
    chk("coin+start NumGames", 8'(NumGames), 8'd7);

    // Load rules with a single paid game.
    do_reset();
    coin();
    start(1'b0);
    chk("start NumGames", 8'(NumGames), 8'd0);
    load(0, 1);
    load(0, 2);
    load(1, 0);
    load(1, 2);
    load(2, 3);
    ShapeLocation = 2'd3;
    LoadShape = 3'd4;
    LoadShapeNow = 1'b1;
    tick();
    LoadShapeNow = 1'b0;
    m_master[3] = 4;
    chk("last load Loading", 8'(Loading), 8'd1);
    tick();
    m_phase = 2;
    chk("guess entry Loading", 8'(Loading), 8'd0);
    check_all("loaded");

    grade(12'b001_010_011_100);
    chk("perm Znarly", 8'(Znarly), 8'd0);
    chk("perm Zood", 8'(Zood), 8'd4);
    chk("perm Round", 8'(RoundNumber), 8'd1);
    grade(12'b100_011_010_001);
    chk("exact GameWon", 8'(GameWon), 8'd1);
    start(1'b0);

    // Duplicate codes.
    new_game(12'b001_001_010_011);
    grade(12'b001_011_001_001);
    chk("dup Znarly", 8'(Znarly), 8'd1);
    chk("dup Zood", 8'(Zood), 8'd2);

    // Round limit, then a late grade.
    p = rand_master();
    new_game(p);
    for (int r = 0; r < 8; r++) grade(losing_guess(p));
    chk("limit Round", 8'(RoundNumber), 8'd8);
    chk("limit GameOver", 8'(GameOver), 8'd1);
    grade(p);
    chk("late GameWon", 8'(GameWon), 8'd0);

    // Win on the third guess.
    p = rand_master();
    new_game(p);
    grade(losing_guess(p));
    grade(losing_guess(p));
    grade(p);
    chk("win3 Round", 8'(RoundNumber), 8'd3);
    chk("win3 GameOver", 8'(GameOver), 8'd1);

    // GradeIt held high across GUESS entry.
    p = rand_master();
    coin();
    start(1'b0);
    Guess = p;
    GradeIt = 1'b1;
    load_pattern(p);
    tick();
    tick();
    check_all("held");
    GradeIt = 1'b0;
    tick();
    grade(p);

    // Reset while in GRADE.
    p = rand_master();
    coin();
    coin();
    new_game(p);
    grade(losing_guess(p));
    Guess = p;
    GradeIt = 1'b1;
    tick();
    GradeIt = 1'b0;
    do_reset();
    check_all("reset in grade");
    chk("reset Round", 8'(RoundNumber), 8'd0);

    // Randomized games with stray coins and bad loads.
    for (int gm = 0; gm < 6; gm++) begin
      coin();
      if ($urandom_range(0, 1) == 1) coin();
      start(1'b0);
      for (int k = 0; k < 100 && m_phase == 1; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          coin();
          start(1'b0);
        end else begin
          load($urandom_range(0, 3), $urandom_range(0, 7));
        end
      end
      for (int k = 0; k < 10 && m_phase == 2; k++) begin
        if ($urandom_range(0, 5) == 0)
          grade(packed_master());
        else
          grade(12'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
